// File: rtl/alu_decoder_pkg.sv
// Shared decode definitions for the RV32I decode stage.
// ALU opcodes are also consumed by the ALU itself.
package alu_decoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_SLL     = 4'd2,
        ALU_SLT     = 4'd3,
        ALU_SLTU    = 4'd4,
        ALU_XOR     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_OR      = 4'd8,
        ALU_AND     = 4'd9,
        ALU_INVALID = 4'd15
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        branch;
        logic [2:0]  br_cond;
        logic        jump;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_gen(
        input logic [31:0] x,
        input imm_fmt_e    f
    );
        logic [31:0] r;
        case (f)
            IMM_I:   r = {{20{x[31]}}, x[31:20]};
            IMM_S:   r = {{20{x[31]}}, x[31:25], x[11:7]};
            IMM_B:   r = {{19{x[31]}}, x[31], x[7],
                          x[30:25], x[11:8], 1'b0};
            IMM_U:   r = {x[31:12], 12'b0};
            IMM_J:   r = {{11{x[31]}}, x[31], x[19:12],
                          x[20], x[30:21], 1'b0};
            IMM_SH:  r = {27'b0, x[24:20]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic alu_op_e f3_alu(input logic [2:0] f3);
        alu_op_e r;
        case (f3)
            3'd0:    r = ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_SLTU;
            3'd4:    r = ALU_XOR;
            3'd5:    r = ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder_comb.sv
// Pure combinational RV32I instruction to bundle decode.
// Illegal encodings keep indices but kill all side effects.
module alu_decoder_comb
    import alu_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    imm_fmt_e   fmt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // decode opcode/funct fields into the execute bundle
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        fmt       = IMM_NONE;
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.rd    = instr[11:7];
        unique case (1'b1)
            opc == OPC_OP: begin
                dec.a_sel = A_RS1;
                dec.b_sel = B_RS2;
                dec.we    = 1'b1;
                if (f7 == F7_ZERO)
                    dec.alu_op = f3_alu(f3);
                else if (f7 == F7_ALT && f3 == 3'd0)
                    dec.alu_op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'd5)
                    dec.alu_op = ALU_SRA;
                else
                    legal = 1'b0;
            end
            opc == OPC_OP_IMM: begin
                dec.a_sel  = A_RS1;
                dec.b_sel  = B_IMM;
                dec.we     = 1'b1;
                dec.alu_op = f3_alu(f3);
                fmt        = IMM_I;
                if (f3 == 3'd1) begin
                    fmt = IMM_SH;
                    if (f7 != F7_ZERO)
                        legal = 1'b0;
                end else if (f3 == 3'd5) begin
                    fmt = IMM_SH;
                    if (f7 == F7_ALT)
                        dec.alu_op = ALU_SRA;
                    else if (f7 != F7_ZERO)
                        legal = 1'b0;
                end
            end
            opc == OPC_LUI: begin
                dec.a_sel = A_ZERO;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
                fmt       = IMM_U;
            end
            opc == OPC_AUIPC: begin
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
                fmt       = IMM_U;
            end
            opc == OPC_JAL: begin
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
                dec.jump  = 1'b1;
                fmt       = IMM_J;
            end
            opc == OPC_JALR: begin
                dec.a_sel = A_RS1;
                dec.b_sel = B_IMM;
                dec.we    = 1'b1;
                dec.jump  = 1'b1;
                fmt       = IMM_I;
                legal     = (f3 == 3'd0);
            end
            opc == OPC_BRANCH: begin
                dec.a_sel   = A_RS1;
                dec.b_sel   = B_RS2;
                dec.branch  = 1'b1;
                dec.br_cond = f3;
                fmt         = IMM_B;
                if (f3[2:1] == 2'b00)
                    dec.alu_op = ALU_SUB;
                else if (f3[2:1] == 2'b10)
                    dec.alu_op = ALU_SLT;
                else if (f3[2:1] == 2'b11)
                    dec.alu_op = ALU_SLTU;
                else
                    legal = 1'b0;
            end
            opc == OPC_LOAD: begin
                dec.a_sel  = A_RS1;
                dec.b_sel  = B_IMM;
                dec.we     = 1'b1;
                dec.mem_rd = 1'b1;
                fmt        = IMM_I;
                legal      = (f3 != 3'd3) && (f3 < 3'd6);
            end
            opc == OPC_STORE: begin
                dec.a_sel  = A_RS1;
                dec.b_sel  = B_IMM;
                dec.mem_wr = 1'b1;
                fmt        = IMM_S;
                legal      = (f3 <= 3'd2);
            end
            default: legal = 1'b0;
        endcase
        dec.imm = imm_gen(instr, fmt);
        if (!legal) begin
            dec.alu_op  = ALU_INVALID;
            dec.a_sel   = A_RS1;
            dec.b_sel   = B_RS2;
            dec.imm     = '0;
            dec.we      = 1'b0;
            dec.branch  = 1'b0;
            dec.br_cond = 3'd0;
            dec.jump    = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0)
            dec.we = 1'b0;
    end

endmodule

// File: rtl/alu_decoder.sv
// RV32I decode stage: handshake plus one pipeline register.
// Empty stage presents an all-zero bundle and RESET_PC.
module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_alu_op,
    output logic [1:0]  o_a_sel,
    output logic        o_b_sel,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_we,
    output logic        o_branch,
    output logic [2:0]  o_br_cond,
    output logic        o_jump,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_illegal,
    output logic [31:0] o_pc
);

    dec_t        dec_d;
    dec_t        dec_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        accept;

    alu_decoder_comb u_comb (
        .instr (i_instr),
        .dec   (dec_d)
    );

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready && !i_flush;

    // pipeline register: load on accept, clear on drain/flush/reset
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= RESET_PC;
        end else if (accept) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
            pc_q    <= i_pc;
        end else if (i_ready) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= RESET_PC;
        end
    end

    assign o_valid   = valid_q;
    assign o_alu_op  = dec_q.alu_op;
    assign o_a_sel   = dec_q.a_sel;
    assign o_b_sel   = dec_q.b_sel;
    assign o_imm     = dec_q.imm;
    assign o_rs1     = dec_q.rs1;
    assign o_rs2     = dec_q.rs2;
    assign o_rd      = dec_q.rd;
    assign o_we      = dec_q.we;
    assign o_branch  = dec_q.branch;
    assign o_br_cond = dec_q.br_cond;
    assign o_jump    = dec_q.jump;
    assign o_mem_rd  = dec_q.mem_rd;
    assign o_mem_wr  = dec_q.mem_wr;
    assign o_illegal = dec_q.illegal;
    assign o_pc      = pc_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Bench for alu_decoder: directed literal cases plus random
// traffic compared each cycle against a behavioural model.
module tb_alu_decoder;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [3:0]  o_alu_op;
    logic [1:0]  o_a_sel;
    logic        o_b_sel;
    logic [31:0] o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic        o_we, o_branch, o_jump;
    logic [2:0]  o_br_cond;
    logic        o_mem_rd, o_mem_wr, o_illegal;
    logic [31:0] o_pc;

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    alu_decoder #(.RESET_PC(RPC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_alu_op(o_alu_op), .o_a_sel(o_a_sel),
        .o_b_sel(o_b_sel), .o_imm(o_imm),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_we(o_we), .o_branch(o_branch),
        .o_br_cond(o_br_cond), .o_jump(o_jump),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
        .o_illegal(o_illegal), .o_pc(o_pc)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic        we, br, jmp, rd, wr, ill;
        logic [2:0]  cond;
    } exp_t;

    // expected decode straight from the ISA rules
    function automatic exp_t model(input logic [31:0] x);
        exp_t e;
        int map [8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        map = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3 = x[14:12];
        f7 = x[31:25];
        ii = {{20{x[31]}}, x[31:20]};
        is = {{20{x[31]}}, x[31:25], x[11:7]};
        ib = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
        iu = {x[31:12], 12'h000};
        ij = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        e = '0;
        case (x[6:0])
            7'h33: begin
                e.we = 1;
                if (f7 == 0) e.op = 4'(map[f3]);
                else if (f7 == 7'h20 && f3 == 0) e.op = 1;
                else if (f7 == 7'h20 && f3 == 5) e.op = 7;
                else e.ill = 1;
            end
            7'h13: begin
                e.b = 1; e.we = 1; e.imm = ii;
                e.op = 4'(map[f3]);
                if (f3 == 1) begin
                    e.imm = 32'(x[24:20]);
                    if (f7 != 0) e.ill = 1;
                end else if (f3 == 5) begin
                    e.imm = 32'(x[24:20]);
                    if (f7 == 7'h20) e.op = 7;
                    else if (f7 != 0) e.ill = 1;
                end
            end
            7'h37: begin e.a = 2; e.b = 1; e.imm = iu; e.we = 1; end
            7'h17: begin e.a = 1; e.b = 1; e.imm = iu; e.we = 1; end
            7'h6f: begin
                e.a = 1; e.b = 1; e.imm = ij; e.we = 1; e.jmp = 1;
            end
            7'h67: begin
                e.b = 1; e.imm = ii; e.we = 1; e.jmp = 1;
                if (f3 != 0) e.ill = 1;
            end
            7'h63: begin
                e.br = 1; e.cond = f3; e.imm = ib;
                if (f3 < 2) e.op = 1;
                else if (f3 < 4) e.ill = 1;
                else if (f3 < 6) e.op = 3;
                else e.op = 4;
            end
            7'h03: begin
                e.b = 1; e.imm = ii; e.rd = 1; e.we = 1;
                if (f3 == 3 || f3 > 5) e.ill = 1;
            end
            7'h23: begin
                e.b = 1; e.imm = is; e.wr = 1;
                if (f3 > 2) e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.op = 15; e.we = 0; e.br = 0; e.jmp = 0;
            e.rd = 0; e.wr = 0;
        end
        if (x[11:7] == 0) e.we = 0;
        return e;
    endfunction

    logic        m_v = 1'b0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_pc = '0;

    // handshake model: what the stage must be holding
    always @(posedge clk) begin
        if (i_rst || i_flush) m_v <= 1'b0;
        else if (i_valid && (!m_v || i_ready)) begin
            m_v   <= 1'b1;
            m_ins <= i_instr;
            m_pc  <= i_pc;
        end else if (i_ready) m_v <= 1'b0;
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            exp_t e;
            e = model(m_ins);
            chk("valid", 32'(o_valid), 32'(m_v));
            chk("ready", 32'(o_ready), 32'(!m_v || i_ready));
            if (m_v) begin
                chk("pc", o_pc, m_pc);
                chk("op", 32'(o_alu_op), 32'(e.op));
                chk("ill", 32'(o_illegal), 32'(e.ill));
                chk("we", 32'(o_we), 32'(e.we));
                chk("br", 32'(o_branch), 32'(e.br));
                chk("jmp", 32'(o_jump), 32'(e.jmp));
                chk("mrd", 32'(o_mem_rd), 32'(e.rd));
                chk("mwr", 32'(o_mem_wr), 32'(e.wr));
                chk("rs1", 32'(o_rs1), 32'(m_ins[19:15]));
                chk("rs2", 32'(o_rs2), 32'(m_ins[24:20]));
                chk("rd", 32'(o_rd), 32'(m_ins[11:7]));
                if (!e.ill) begin
                    chk("asel", 32'(o_a_sel), 32'(e.a));
                    chk("bsel", 32'(o_b_sel), 32'(e.b));
                    if (e.b || e.br) chk("imm", o_imm, e.imm);
                    if (e.br) chk("cond", 32'(o_br_cond), 32'(e.cond));
                end
            end else begin
                chk("pc_empty", o_pc, RPC);
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins,
                        input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = ins;
        i_pc    = pc;
        go();
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [9];
        logic [31:0] x;
        int k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f,
                7'h67, 7'h63, 7'h03, 7'h23};
        x = $urandom;
        k = int'($urandom_range(0, 9));
        if (k < 9) x[6:0] = ops[k];
        case ($urandom_range(0, 2))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        go();
        go();
        i_rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_pc", o_pc, RPC);
        chk("rst_op", 32'(o_alu_op), 0);
        chk("rst_imm", o_imm, 0);
        chk("rst_ready", 32'(o_ready), 1);
        go();

        send(32'h002081B3, 32'h10);
        @(negedge clk);
        chk("add_valid", 32'(o_valid), 1);
        chk("add_op", 32'(o_alu_op), 0);
        chk("add_asel", 32'(o_a_sel), 0);
        chk("add_bsel", 32'(o_b_sel), 0);
        chk("add_rs1", 32'(o_rs1), 1);
        chk("add_rs2", 32'(o_rs2), 2);
        chk("add_rd", 32'(o_rd), 3);
        chk("add_we", 32'(o_we), 1);
        go();

        send(32'h40335293, 32'h14);
        @(negedge clk);
        chk("srai_op", 32'(o_alu_op), 7);
        chk("srai_bsel", 32'(o_b_sel), 1);
        chk("srai_imm", o_imm, 3);
        chk("srai_rd", 32'(o_rd), 5);
        chk("srai_we", 32'(o_we), 1);
        go();

        send(32'h42335293, 32'h18);
        @(negedge clk);
        chk("badsh_ill", 32'(o_illegal), 1);
        chk("badsh_op", 32'(o_alu_op), 15);
        chk("badsh_we", 32'(o_we), 0);
        go();

        send(32'h123453B7, 32'h1C);
        @(negedge clk);
        chk("lui_asel", 32'(o_a_sel), 2);
        chk("lui_imm", o_imm, 32'h12345000);
        chk("lui_op", 32'(o_alu_op), 0);
        go();

        send(32'h0020E463, 32'h20);
        @(negedge clk);
        chk("bltu_op", 32'(o_alu_op), 4);
        chk("bltu_br", 32'(o_branch), 1);
        chk("bltu_cond", 32'(o_br_cond), 6);
        chk("bltu_imm", o_imm, 8);
        chk("bltu_we", 32'(o_we), 0);
        go();

        i_ready = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h002081B3;
        i_pc    = 32'h100;
        go();
        i_instr = 32'h40335293;
        i_pc    = 32'h104;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(o_ready), 0);
            chk("bp_valid", 32'(o_valid), 1);
            chk("bp_pc", o_pc, 32'h100);
            chk("bp_op", 32'(o_alu_op), 0);
            go();
        end
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            go();
            i_pc = 32'h108 + 32'(4 * k);
            @(negedge clk);
            chk("b2b_valid", 32'(o_valid), 1);
            chk("b2b_pc", o_pc, 32'h104 + 32'(4 * k));
        end
        go();
        i_flush = 1'b1;
        i_pc    = 32'h200;
        go();
        i_flush = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("fl_valid", 32'(o_valid), 0);
            chk("fl_pc", o_pc, RPC);
            go();
        end

        send(32'h002081B3, 32'h300);
        i_valid = 1'b1;
        i_pc    = 32'h304;
        i_rst   = 1'b1;
        go();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(o_valid), 0);
        chk("mrst_pc", o_pc, RPC);
        go();
        send(32'h00000000, 32'h400);
        @(negedge clk);
        chk("zero_ill", 32'(o_illegal), 1);
        chk("zero_op", 32'(o_alu_op), 15);
        chk("zero_pc", o_pc, 32'h400);
        go();

        for (int c = 0; c < 4000; c++) begin
            i_rst   = ($urandom_range(0, 199) == 0);
            i_flush = ($urandom_range(0, 19) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_instr = rnd_instr();
            i_pc    = {$urandom_range(0, 32'hFFFF), 2'b00};
            go();
        end
        i_rst   = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        go();
        go();
        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
